rip_axi_arbiter: RTL
====================

// Module: rip_axi_arbiter
// PURPOSE
//  Shares one rip_axi_master between NUM_REQ requesters (e.g. icache=0, dcache=1).
//  Write and read paths are arbitrated independently, each with its own round-robin pointer.
//  Presents the master's simple valid/done access protocol to every requester.
//  Sits between the cache controllers and the AXI master in the memory subsystem.
// PARAMETERS
//  NUM_REQ    2   number of requesters (>=2)
//  ADDR_WIDTH 32  access address width
//  DATA_WIDTH 32  AXI beat width
//  BURST_LEN  1   beats per access; line width LW = DATA_WIDTH*BURST_LEN
//  Derived: GW = $clog2(NUM_REQ)
// PORTS
//  clk         in   1               clock
//  rstn        in   1               reset; asynchronous, active-low
//  req_wvalid  in   NUM_REQ         per-requester write request; held until its req_wdone
//  req_waddr   in   NUM_REQ*ADDR_W  write address of requester i, at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata   in   NUM_REQ*LW      write line of requester i, at slice [i*LW +: LW]
//  req_wdone   out  NUM_REQ         one-cycle completion pulse for the write
//  req_rvalid  in   NUM_REQ         per-requester read request; held until its req_rdone
//  req_raddr   in   NUM_REQ*ADDR_W  read address of requester i
//  req_rdata   out  LW              shared read-return line; valid while any req_rdone bit is high
//  req_rdone   out  NUM_REQ         one-cycle read completion pulse
//  wgrant      out  GW              index of the current/last write grantee
//  rgrant      out  GW              index of the current/last read grantee
//  m_wready    in   1               master write-side ready
//  m_waddr     out  ADDR_WIDTH      to master waddr
//  m_wdata     out  LW              to master wdata
//  m_wvalid    out  1               to master wvalid
//  m_wdone     in   1               master write completion pulse
//  m_rready    in   1               master read-side ready
//  m_raddr     out  ADDR_WIDTH      to master raddr
//  m_rvalid    out  1               to master rvalid
//  m_rdata     in   LW              master read line
//  m_rdone     in   1               master read completion pulse
// BEHAVIOUR
//  Reset (async, rstn=0)
//   - All outputs are 0; both FSMs go to IDLE; both RR pointers are 0.
//   - An access in flight is abandoned; no done pulse is ever emitted for it.
//  FSM (identical per path; write shown, read path mirrors with r* signals)
//   IDLE  - eligible = req_wvalid & ~req_wdone (masks the requester completing this cycle).
//         - If eligible != 0: g = first set bit scanning ptr, ptr+1, ... (mod NUM_REQ).
//         - Register wgrant=g, m_waddr/m_wdata = slice g, m_wvalid=1; go to ISSUE.
//   ISSUE - Hold m_wvalid and payload stable.
//         - When m_wready && m_wvalid: m_wvalid<=0; go to WAIT.
//   WAIT  - When m_wdone: req_wdone[wgrant]<=1 for exactly one cycle;
//           ptr <= (wgrant==NUM_REQ-1) ? 0 : wgrant+1; go to IDLE.
//         - The read path additionally latches req_rdata <= m_rdata in the same edge.
//  Latency
//   - req_*valid to m_*valid: 1 cycle.
//   - m_*done to req_*done: 1 cycle.
//   - Back-to-back grants: a new grant can issue in the cycle after req_*done.
//  Concurrency and fairness
//   - Read and write paths run concurrently and never interact; ordering between them
//     is the requester's responsibility.
//   - Simultaneous requests are resolved by ptr only. A waiting requester is served
//     within NUM_REQ grants.
//   - req_* inputs of non-granted requesters are ignored; changes to them are harmless.
//   - Requester deasserting valid before its done: the access still completes and the
//     done pulse is still emitted.
//   - m_*done seen outside WAIT is ignored.
// TESTING
//  1. Single write: req0 waddr=0x100, wdata=0xA5A5A5A5 -> m_wvalid after 1 cycle with
//     those values; m_wdone -> req_wdone=2'b01 for 1 cycle.
//  2. Contention: req0 and req1 read in the same cycle after reset -> rgrant=0 first,
//     then 1; req_rdata=0x11 and then 0x22 match the m_rdata returned for each.
//  3. Fairness: both requesters issue 4 writes each, back-to-back -> grants strictly
//     alternate 0,1,0,1,...; no repeat grant in the cycle req_wdone is high.
//  4. Parallel paths: write by req1 and read by req0 overlapping -> both proceed;
//     wgrant=1, rgrant=0; done pulses are independent.
//  5. Stalled master: m_wready=0 for 5 cycles in ISSUE -> m_wvalid and m_waddr held
//     stable; accepted on the first cycle m_wready=1.
//  6. Reset mid-WAIT: rstn=0 asynchronously -> outputs 0 immediately; after release,
//     a new req1 read is granted with ptr=0 priority.

Source files
------------

// File: rtl/rip_axi_arbiter.sv
// rip_axi_arbiter: shares one AXI master between NUM_REQ requesters, with
// independent round-robin arbitration of the write and read paths.
module rip_axi_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 1,
  localparam int LW = DATA_WIDTH * BURST_LEN,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_wvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr,
  input  logic [NUM_REQ*LW-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]            req_wdone,
  input  logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_raddr,
  output logic [LW-1:0]                 req_rdata,
  output logic [NUM_REQ-1:0]            req_rdone,
  output logic [GW-1:0]                 wgrant,
  output logic [GW-1:0]                 rgrant,
  input  logic                          m_wready,
  output logic [ADDR_WIDTH-1:0]         m_waddr,
  output logic [LW-1:0]                 m_wdata,
  output logic                          m_wvalid,
  input  logic                          m_wdone,
  input  logic                          m_rready,
  output logic [ADDR_WIDTH-1:0]         m_raddr,
  output logic                          m_rvalid,
  input  logic [LW-1:0]                 m_rdata,
  input  logic                          m_rdone
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                            input logic [GW-1:0] ptr);
    logic [2*NUM_REQ-1:0] rot;
    logic [GW-1:0] g;
    logic found;
    rot = {elig, elig} >> ptr;
    g = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        g = GW'((int'(ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
    return (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0] waddr_a [NUM_REQ];
  logic [LW-1:0]         wdata_a [NUM_REQ];
  logic [ADDR_WIDTH-1:0] raddr_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign waddr_a[i] = req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*LW +: LW];
    assign raddr_a[i] = req_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  state_e                ws_q, ws_d;
  logic [GW-1:0]         wptr_q, wptr_d, wgrant_q, wgrant_d, wpick;
  logic [ADDR_WIDTH-1:0] m_waddr_q, m_waddr_d;
  logic [LW-1:0]         m_wdata_q, m_wdata_d;
  logic                  m_wvalid_q, m_wvalid_d;
  logic [NUM_REQ-1:0]    req_wdone_q, req_wdone_d, welig;

  state_e                rs_q, rs_d;
  logic [GW-1:0]         rptr_q, rptr_d, rgrant_q, rgrant_d, rpick;
  logic [ADDR_WIDTH-1:0] m_raddr_q, m_raddr_d;
  logic                  m_rvalid_q, m_rvalid_d;
  logic [LW-1:0]         req_rdata_q, req_rdata_d;
  logic [NUM_REQ-1:0]    req_rdone_q, req_rdone_d, relig;

  // A requester whose done pulse is high this cycle must not be re-granted on it.
  assign welig = req_wvalid & ~req_wdone_q;
  assign relig = req_rvalid & ~req_rdone_q;
  assign wpick = rr_pick(welig, wptr_q);
  assign rpick = rr_pick(relig, rptr_q);

  always_comb begin
    ws_d        = ws_q;
    wptr_d      = wptr_q;
    wgrant_d    = wgrant_q;
    m_waddr_d   = m_waddr_q;
    m_wdata_d   = m_wdata_q;
    m_wvalid_d  = m_wvalid_q;
    req_wdone_d = '0;
    case (ws_q)
      IDLE: if (|welig) begin
        wgrant_d   = wpick;
        m_waddr_d  = waddr_a[wpick];
        m_wdata_d  = wdata_a[wpick];
        m_wvalid_d = 1'b1;
        ws_d       = ISSUE;
      end
      ISSUE: if (m_wready) begin
        m_wvalid_d = 1'b0;
        ws_d       = WAIT;
      end
      WAIT: if (m_wdone) begin
        req_wdone_d[wgrant_q] = 1'b1;
        wptr_d = rr_next(wgrant_q);
        ws_d   = IDLE;
      end
      default: ws_d = IDLE;
    endcase
  end

  always_comb begin
    rs_d        = rs_q;
    rptr_d      = rptr_q;
    rgrant_d    = rgrant_q;
    m_raddr_d   = m_raddr_q;
    m_rvalid_d  = m_rvalid_q;
    req_rdata_d = req_rdata_q;
    req_rdone_d = '0;
    case (rs_q)
      IDLE: if (|relig) begin
        rgrant_d   = rpick;
        m_raddr_d  = raddr_a[rpick];
        m_rvalid_d = 1'b1;
        rs_d       = ISSUE;
      end
      ISSUE: if (m_rready) begin
        m_rvalid_d = 1'b0;
        rs_d       = WAIT;
      end
      WAIT: if (m_rdone) begin
        req_rdone_d[rgrant_q] = 1'b1;
        req_rdata_d = m_rdata;
        rptr_d = rr_next(rgrant_q);
        rs_d   = IDLE;
      end
      default: rs_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ws_q        <= IDLE;
      wptr_q      <= '0;
      wgrant_q    <= '0;
      m_waddr_q   <= '0;
      m_wdata_q   <= '0;
      m_wvalid_q  <= 1'b0;
      req_wdone_q <= '0;
      rs_q        <= IDLE;
      rptr_q      <= '0;
      rgrant_q    <= '0;
      m_raddr_q   <= '0;
      m_rvalid_q  <= 1'b0;
      req_rdata_q <= '0;
      req_rdone_q <= '0;
    end else begin
      ws_q        <= ws_d;
      wptr_q      <= wptr_d;
      wgrant_q    <= wgrant_d;
      m_waddr_q   <= m_waddr_d;
      m_wdata_q   <= m_wdata_d;
      m_wvalid_q  <= m_wvalid_d;
      req_wdone_q <= req_wdone_d;
      rs_q        <= rs_d;
      rptr_q      <= rptr_d;
      rgrant_q    <= rgrant_d;
      m_raddr_q   <= m_raddr_d;
      m_rvalid_q  <= m_rvalid_d;
      req_rdata_q <= req_rdata_d;
      req_rdone_q <= req_rdone_d;
    end
  end

  assign req_wdone = req_wdone_q;
  assign wgrant    = wgrant_q;
  assign m_waddr   = m_waddr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wvalid  = m_wvalid_q;
  assign req_rdone = req_rdone_q;
  assign req_rdata = req_rdata_q;
  assign rgrant    = rgrant_q;
  assign m_raddr   = m_raddr_q;
  assign m_rvalid  = m_rvalid_q;
endmodule
